// File: rtl/outerprodrc_ctrl.sv
// outerprodrc_ctrl: sequencing controller for the unary outer-product GEMM array.
// A job of N K-tiles is handled in this order: one accumulator clear, then for
// each tile an operand fetch and one full unary stream of array enables, then a
// drain of the array pipeline, and finally a held result-valid handshake.
// Optional feature macro: OUTERPRODRC_CTRL_PERFCNT_EN adds a 32-bit busy-cycle
// counter on output oCycCnt.
//
// Handshakes: oRdReq/iRdVld completes an operand fetch in the first cycle where
// both are high. oVld/iRdy completes the result transfer in the first cycle where
// both are high. oVld stays high until that cycle, and iAbort has priority over it.
// Every output is decoded from registered state or counters.
module outerprodrc_ctrl #(
  parameter int BITWIDTH = 8,
  parameter int TILEW    = 8,
  parameter int PIPE     = 2
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [TILEW-1:0] iTileNum,
  input  logic             iAbort,
  output logic             oBusy,
  output logic             oRdReq,
  input  logic             iRdVld,
  output logic [TILEW-1:0] oTileIdx,
  output logic             oArrClr,
  output logic             oArrEn,
  output logic             oVld,
  input  logic             iRdy
`ifdef OUTERPRODRC_CTRL_PERFCNT_EN
  ,
  output logic [31:0]      oCycCnt
`endif
);

  localparam int RUNLEN = 2 ** BITWIDTH;
  localparam int DW     = (PIPE > 1) ? $clog2(PIPE) : 1;

  localparam logic [BITWIDTH:0] RUN_LAST   = (BITWIDTH + 1)'(RUNLEN - 1);
  localparam logic [DW-1:0]     DRAIN_LAST = DW'((PIPE > 0) ? (PIPE - 1) : 0);
  localparam logic [TILEW-1:0]  TILE_ONE   = TILEW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_FETCH = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [TILEW-1:0]  tile_num;
  logic [TILEW-1:0]  tile_idx;
  logic [BITWIDTH:0] run_cnt;
  logic [DW-1:0]     drain_cnt;

  logic run_last;
  logic tile_last;
  logic drain_last;
  logic start_ok;

  assign start_ok   = (state == S_IDLE) && iStart;
  assign run_last   = (run_cnt == RUN_LAST);
  // Only evaluated in RUN, where tile_num is known to be non-zero.
  assign tile_last  = (tile_idx == (tile_num - TILE_ONE));
  assign drain_last = (drain_cnt == DRAIN_LAST);

  // Next-state decode; abort overrides every other transition out of a busy state.
  always_comb begin
    state_nxt = state;
    if ((state != S_IDLE) && iAbort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (iStart) state_nxt = S_CLR;
        S_CLR:   state_nxt = (tile_num == '0) ? S_DONE : S_FETCH;
        S_FETCH: if (iRdVld) state_nxt = S_RUN;
        S_RUN: begin
          if (run_last) begin
            if (!tile_last)     state_nxt = S_FETCH;
            else if (PIPE == 0) state_nxt = S_DONE;
            else                state_nxt = S_DRAIN;
          end
        end
        S_DRAIN: if (drain_last) state_nxt = S_DONE;
        S_DONE:  if (iRdy) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Job bookkeeping: latched tile count and current tile index.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      tile_num <= '0;
      tile_idx <= '0;
    end else if (start_ok) begin
      tile_num <= iTileNum;
      tile_idx <= '0;
    end else if ((state == S_RUN) && run_last && !tile_last && !iAbort) begin
      tile_idx <= tile_idx + TILE_ONE;
    end
  end

  // Stream-length counter; restarts from zero on every entry into RUN.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst)                run_cnt <= '0;
    else if (state == S_RUN) run_cnt <= run_cnt + 1'b1;
    else                     run_cnt <= '0;
  end

  // Pipeline drain counter; restarts from zero on every entry into DRAIN.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst)                  drain_cnt <= '0;
    else if (state == S_DRAIN) drain_cnt <= drain_cnt + 1'b1;
    else                       drain_cnt <= '0;
  end

`ifdef OUTERPRODRC_CTRL_PERFCNT_EN
  logic [31:0] cyc_cnt;

  // Busy-cycle counter: cleared on job acceptance, saturating, held through IDLE.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst)                                       cyc_cnt <= '0;
    else if (start_ok)                              cyc_cnt <= '0;
    else if ((state != S_IDLE) && (cyc_cnt != '1))  cyc_cnt <= cyc_cnt + 32'd1;
  end

  assign oCycCnt = cyc_cnt;
`endif

  assign oBusy    = (state != S_IDLE);
  assign oArrClr  = (state == S_CLR);
  assign oRdReq   = (state == S_FETCH);
  assign oArrEn   = (state == S_RUN);
  assign oVld     = (state == S_DONE);
  assign oTileIdx = tile_idx;

endmodule

// File: tb/tb_outerprodrc_ctrl.sv
// Directed bench for outerprodrc_ctrl (BITWIDTH=4 -> RUNLEN=16, PIPE=2).
// Cycle k is the clock period that follows edge k-1, where edge 0 is the edge
// that samples iStart. Inputs change 1 time unit after a rising edge or at the
// falling edge, and outputs are sampled at the falling edge.
module tb_outerprodrc_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] tile_num;
  logic       abort;
  logic       busy;
  logic       rd_req;
  logic       rd_vld;
  logic [7:0] tile_idx;
  logic       arr_clr;
  logic       arr_en;
  logic       vld;
  logic       rdy;
`ifdef OUTERPRODRC_CTRL_PERFCNT_EN
  logic [31:0] cyc_cnt;
`endif

  int checks;
  int errors;

  // Trace results of the most recent job.
  int t_clr_first, t_clr_cnt, t_en_first, t_en_last, t_en_cnt, t_req_cnt;
  int t_vld_first, t_vld_cnt, t_busy_low, t_overlap;
  bit t_idle_ok, t_done;
  logic [7:0] idx_q[$];

  outerprodrc_ctrl #(.BITWIDTH(4), .TILEW(8), .PIPE(2)) dut (
    .iClk(clk), .iRst(rst), .iStart(start), .iTileNum(tile_num), .iAbort(abort),
    .oBusy(busy), .oRdReq(rd_req), .iRdVld(rd_vld), .oTileIdx(tile_idx),
    .oArrClr(arr_clr), .oArrEn(arr_en), .oVld(vld), .iRdy(rdy)
`ifdef OUTERPRODRC_CTRL_PERFCNT_EN
    , .oCycCnt(cyc_cnt)
`endif
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one job from IDLE and record what the controller does, cycle by cycle.
  // stall_fetch/stall_len: hold iRdVld low for stall_len cycles in that FETCH (1-based).
  // rdy_low: hold iRdy low for that many DONE cycles; start_in_done pulses iStart then.
  task automatic run_trace(input logic [7:0] n, input int stall_fetch, input int stall_len,
                           input int rdy_low, input bit start_in_done);
    int c, fetch_no, stall_left, rdy_left;
    logic prev_req, prev_en;
    t_clr_first = -1; t_clr_cnt = 0; t_en_first = -1; t_en_last = -1; t_en_cnt = 0;
    t_req_cnt = 0; t_vld_first = -1; t_vld_cnt = 0; t_busy_low = -1; t_overlap = 0;
    t_idle_ok = 1'b0; t_done = 1'b0; idx_q.delete();
    fetch_no = 0; stall_left = 0; rdy_left = rdy_low; prev_req = 1'b0; prev_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; tile_num = n; rd_vld = 1'b1; rdy = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    while (c <= 300) begin
      @(negedge clk);
      if (t_busy_low >= 0 && c == t_busy_low + 1) begin
        t_idle_ok = !busy;
        t_done = 1'b1;
        break;
      end
      if (!busy && t_busy_low < 0) t_busy_low = c;
      if (arr_clr) begin
        t_clr_cnt++;
        if (t_clr_first < 0) t_clr_first = c;
      end
      if (arr_en) begin
        t_en_cnt++;
        if (t_en_first < 0) t_en_first = c;
        t_en_last = c;
        if (!prev_en) idx_q.push_back(tile_idx);
      end
      if (rd_req) t_req_cnt++;
      if (arr_en && (arr_clr || rd_req)) t_overlap++;
      if (vld) begin
        t_vld_cnt++;
        if (t_vld_first < 0) t_vld_first = c;
      end
      if (rd_req && !prev_req) begin
        fetch_no++;
        if (fetch_no == stall_fetch) stall_left = stall_len;
      end
      if (rd_req && stall_left > 0) begin
        rd_vld = 1'b0;
        stall_left--;
      end else begin
        rd_vld = 1'b1;
      end
      if (vld && rdy_left > 0) begin
        start = start_in_done && (rdy_left == rdy_low);
        rdy = 1'b0;
        rdy_left--;
      end else begin
        start = 1'b0;
        rdy = 1'b1;
      end
      prev_req = rd_req;
      prev_en = arr_en;
      @(posedge clk);
      c++;
    end
    start = 1'b0; rd_vld = 1'b1; rdy = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; tile_num = 8'd0; abort = 1'b0; rd_vld = 1'b1; rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, rd_req, arr_clr, arr_en, vld, tile_idx} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b req=%b clr=%b en=%b vld=%b idx=%0d, expected all 0",
               busy, rd_req, arr_clr, arr_en, vld, tile_idx);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_single_tile;
    run_trace(8'd1, 0, 0, 0, 1'b0);
    checks++;
    if (!t_done) begin errors++; $display("FAIL single_timeout: job did not finish"); end
    checks++;
    if (t_clr_first !== 1 || t_clr_cnt !== 1) begin
      errors++; $display("FAIL single_clr: first=%0d cnt=%0d expected 1/1", t_clr_first, t_clr_cnt);
    end
    checks++;
    if (t_en_first !== 3 || t_en_last !== 18 || t_en_cnt !== 16) begin
      errors++; $display("FAIL single_en: first=%0d last=%0d cnt=%0d expected 3/18/16",
                         t_en_first, t_en_last, t_en_cnt);
    end
    checks++;
    if (t_vld_first !== 21 || t_vld_cnt !== 1) begin
      errors++; $display("FAIL single_vld: first=%0d cnt=%0d expected 21/1", t_vld_first, t_vld_cnt);
    end
    checks++;
    if (t_busy_low !== 22) begin
      errors++; $display("FAIL single_busy_low: cycle=%0d expected 22", t_busy_low);
    end
    checks++;
    if (t_req_cnt !== 1 || t_overlap !== 0) begin
      errors++; $display("FAIL single_req: req=%0d overlap=%0d expected 1/0", t_req_cnt, t_overlap);
    end
`ifdef OUTERPRODRC_CTRL_PERFCNT_EN
    checks++;
    if (cyc_cnt !== 32'd21) begin
      errors++; $display("FAIL single_cyccnt: got %0d expected 21", cyc_cnt);
    end
`endif
  endtask

  task automatic test_multi_tile_stall;
    run_trace(8'd3, 2, 5, 0, 1'b0);
    checks++;
    if (!t_done) begin errors++; $display("FAIL multi_timeout: job did not finish"); end
    checks++;
    if (t_en_cnt !== 48 || t_clr_cnt !== 1) begin
      errors++; $display("FAIL multi_counts: en=%0d clr=%0d expected 48/1", t_en_cnt, t_clr_cnt);
    end
    checks++;
    if (idx_q.size() !== 3) begin
      errors++; $display("FAIL multi_idx_len: got %0d runs expected 3", idx_q.size());
    end else if (idx_q[0] !== 8'd0 || idx_q[1] !== 8'd1 || idx_q[2] !== 8'd2) begin
      errors++; $display("FAIL multi_idx_seq: got %0d,%0d,%0d expected 0,1,2",
                         idx_q[0], idx_q[1], idx_q[2]);
    end
    checks++;
    if (t_vld_first !== 60 || t_vld_cnt !== 1) begin
      errors++; $display("FAIL multi_vld: first=%0d cnt=%0d expected 60/1", t_vld_first, t_vld_cnt);
    end
    checks++;
    if (t_overlap !== 0 || t_req_cnt !== 8) begin
      errors++; $display("FAIL multi_req: overlap=%0d req=%0d expected 0/8", t_overlap, t_req_cnt);
    end
  endtask

  task automatic test_zero_tiles;
    run_trace(8'd0, 0, 0, 0, 1'b0);
    checks++;
    if (t_clr_first !== 1 || t_vld_first !== 2) begin
      errors++; $display("FAIL zero_timing: clr=%0d vld=%0d expected 1/2", t_clr_first, t_vld_first);
    end
    checks++;
    if (t_en_cnt !== 0 || t_req_cnt !== 0) begin
      errors++; $display("FAIL zero_no_run: en=%0d req=%0d expected 0/0", t_en_cnt, t_req_cnt);
    end
    checks++;
    if (t_busy_low !== 3) begin
      errors++; $display("FAIL zero_busy_low: cycle=%0d expected 3", t_busy_low);
    end
  endtask

  task automatic test_done_backpressure;
    run_trace(8'd1, 0, 0, 10, 1'b1);
    checks++;
    if (t_vld_first !== 21 || t_vld_cnt !== 11) begin
      errors++; $display("FAIL bp_vld: first=%0d cnt=%0d expected 21/11", t_vld_first, t_vld_cnt);
    end
    checks++;
    if (t_busy_low !== 32 || t_idle_ok !== 1'b1) begin
      errors++; $display("FAIL bp_idle: busy_low=%0d idle_next=%b expected 32/1", t_busy_low, t_idle_ok);
    end
  endtask

  task automatic test_reset_in_run;
    @(posedge clk); #1;
    start = 1'b1; tile_num = 8'd2; rd_vld = 1'b1; rdy = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (25) @(posedge clk);
    #3;
    checks++;
    if (arr_en !== 1'b1 || tile_idx !== 8'd1) begin
      errors++; $display("FAIL rst_pre: en=%b idx=%0d expected 1/1", arr_en, tile_idx);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (arr_en !== 1'b0 || busy !== 1'b0 || tile_idx !== 8'd0 || vld !== 1'b0) begin
      errors++; $display("FAIL rst_async: en=%b busy=%b idx=%0d vld=%b expected 0/0/0/0",
                         arr_en, busy, tile_idx, vld);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_abort;
    @(posedge clk); #1;
    start = 1'b1; tile_num = 8'd1; rd_vld = 1'b1; rdy = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (arr_en !== 1'b1) begin
      errors++; $display("FAIL abort_pre: en=%b expected 1", arr_en);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    #3;
    checks++;
    if (arr_en !== 1'b0 || busy !== 1'b0 || rd_req !== 1'b0 || vld !== 1'b0) begin
      errors++; $display("FAIL abort_stop: en=%b busy=%b req=%b vld=%b expected 0/0/0/0",
                         arr_en, busy, rd_req, vld);
    end
    run_trace(8'd1, 0, 0, 0, 1'b0);
    checks++;
    if (t_clr_cnt !== 1 || t_en_cnt !== 16 || t_vld_first !== 21 || t_busy_low !== 22) begin
      errors++; $display("FAIL abort_rerun: clr=%0d en=%0d vld=%0d busy_low=%0d expected 1/16/21/22",
                         t_clr_cnt, t_en_cnt, t_vld_first, t_busy_low);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_tile();
    test_multi_tile_stall();
    test_zero_tiles();
    test_done_backpressure();
    test_reset_in_run();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/outerprodrc_ctrl.md
# outerprodrc_ctrl

Sequencing controller for the unary outer-product GEMM array. It accepts a job of N K-tiles, clears the array accumulators once, then runs each tile in turn. For each tile it fetches operands from the operand buffer and drives the array enable for one full unary stream length. After the last tile it waits out the array pipeline and presents a result-valid handshake to the downstream reader. It sits between the tile scheduler / operand buffer and the outer-product array's `iEn`/`iClr` pins.

## Interface
- `BITWIDTH`, 8: operand bit width; one tile runs `RUNLEN = 2**BITWIDTH` cycles.
- `TILEW`, 8: width of tile count and tile index.
- `PIPE`, 2: array output latency in cycles, drained after the last tile (0 allowed).
- `iClk` in 1: clock, rising edge.
- `iRst` in 1: reset, asynchronous, active-high.
- `iStart` in 1: job request; sampled only in IDLE.
- `iTileNum` in TILEW: tiles in the job; latched with `iStart`.
- `iAbort` in 1: synchronous job cancel.
- `oBusy` out 1: high in every state except IDLE.
- `oRdReq` out 1: operand fetch request for tile `oTileIdx`.
- `iRdVld` in 1: operand buffer has tile `oTileIdx` on the array inputs.
- `oTileIdx` out TILEW: current tile, 0-based.
- `oArrClr` out 1: to array `iClr`.
- `oArrEn` out 1: to array `iEn`.
- `oVld` out 1: array `oData` holds the final job result.
- `iRdy` in 1: downstream accepts the result.

## Operation
- State machine states: IDLE, CLR, FETCH, RUN, DRAIN, DONE.
- All outputs are decoded from registered state/counters; there are no combinational input-to-output paths.
- IDLE: on `iStart=1`, latch `iTileNum`, clear `oTileIdx`, go to CLR. Otherwise hold.
- CLR: `oArrClr=1` for exactly one cycle.
  - If the latched count is 0, go to DONE: result is zero, no fetch, no enable.
  - Otherwise go to FETCH.
- FETCH: `oRdReq=1`. Hold while `iRdVld=0`. In the cycle `iRdVld=1`, go to RUN.
- RUN: `oArrEn=1` for exactly RUNLEN consecutive cycles; the run counter is BITWIDTH+1 bits.
  - `iRdVld` is ignored during RUN. The buffer holds the operands until the next `oRdReq`.
  - After the last RUN cycle, if `oTileIdx` is below count−1: increment `oTileIdx` and go to FETCH.
  - Otherwise go to DRAIN.
- DRAIN: all array controls low for PIPE cycles. PIPE=0 skips DRAIN.
- DONE: `oVld=1`, held until `iRdy=1`. On the handshake cycle, go to IDLE.
- `iStart` while busy: ignored, not queued.
- `iAbort=1` in any non-IDLE state: next state is IDLE. `oArrEn`, `oRdReq` and `oVld` drop on the following cycle. The array is not cleared; the next job's CLR handles it.
- `iAbort` has priority over all other transitions, including the DONE handshake.
- Reset values: state IDLE; all outputs 0; `oTileIdx` 0.

## Timing
- Edge 0 samples `iStart`. The cycle after edge 0 is CLR.
- If `iRdVld` is already high, FETCH lasts 1 cycle.
- RUN occupies cycles 3..RUNLEN+2.
- `oVld` rises RUNLEN+PIPE+3 cycles after edge 0 for a single tile with no stall.
- Each additional tile adds RUNLEN+1 cycles, plus any `iRdVld` stall cycles.
- `oArrEn` is never high in the same cycle as `oArrClr` or `oRdReq`.
- `oArrClr` pulses exactly once per job.
- DONE→IDLE takes one cycle after the `iRdy` handshake. The earliest next `iStart` is sampled in that IDLE cycle.
- Asserting `iRst` mid-operation forces all outputs to 0 immediately, without waiting for a clock edge.

## Configuration
- Macro: `OUTERPRODRC_CTRL_PERFCNT_EN`.
- Defined: adds output `oCycCnt` (32 bits).
  - Cleared when `iStart` is accepted.
  - Increments every cycle `oBusy=1`.
  - Holds its value in IDLE until the next accepted `iStart`.
  - Saturates at all-ones.
- Undefined: neither the port nor the counter exists. All other behaviour is identical.

## Test plan
- BITWIDTH=4, PIPE=2, `iTileNum=1`, `iRdVld` tied 1, `iRdy` 1 → `oArrClr` high in cycle 1, `oArrEn` high in cycles 3..18, `oVld` high in cycle 21 for exactly 1 cycle, `oBusy` low in cycle 22.
- `iTileNum=3`, `iRdVld` low for 5 cycles in the second FETCH → `oArrEn` high for 48 cycles total, `oTileIdx` sequence 0,1,2, one `oArrClr`, `oVld` at cycle 21+2·17+5=60.
- `iTileNum=0` → `oArrClr` in cycle 1, `oVld` in cycle 2, `oArrEn` and `oRdReq` never high.
- `iRdy` low for 10 cycles in DONE with `iStart` pulsed → `oVld` held 11 cycles, `iStart` ignored, IDLE next cycle after the handshake.
- `iRst` asserted in RUN cycle 7 → `oArrEn`, `oBusy`, `oTileIdx` all 0 before the next edge. Separately, `iAbort` in RUN → `oArrEn` 0 and `oBusy` 0 the next cycle, and a new job then runs normally.
- With `OUTERPRODRC_CTRL_PERFCNT_EN` defined, scenario 1 → `oCycCnt`=21 after completion. With it undefined, the port is absent and the build passes.
